// File: rtl/hdbn_pkg.sv
// Shared line-code constants and delay-line slot types for the HDB-n encoder.
package hdbn_pkg;

   // Two-bit ternary line symbols driven toward the line interface.
   localparam logic [1:0] CODE_ZERO = 2'b00;
   localparam logic [1:0] CODE_POS  = 2'b01;
   localparam logic [1:0] CODE_NEG  = 2'b10;

   // Mark carried by each delay-line slot until its polarity is resolved.
   typedef enum logic [1:0] {
      MARK_ZERO = 2'd0,
      MARK_ONE  = 2'd1,
      MARK_B    = 2'd2,
      MARK_V    = 2'd3
   } mark_e;

   // One delay-line slot: occupancy flag plus mark.
   typedef struct packed {
      logic  valid;
      mark_e mark;
   } slot_t;

   localparam int unsigned SLOT_W = $bits(slot_t);

endpackage

// File: rtl/hdbn_polarity.sv
// Stage 2 of the HDB-n encoder: resolves the pulse polarity of each mark
// leaving the delay line and registers the line symbol.
module hdbn_polarity
   import hdbn_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_shift,
   input  logic       i_slot_valid,
   input  logic [1:0] i_mark,
   output logic       o_valid,
   output logic [1:0] o_hdb3_code
);

   logic       r_last_pos;
   logic       w_last_pos_nxt;
   logic       r_valid;
   logic       w_valid_nxt;
   logic [1:0] r_code;
   logic [1:0] w_code_nxt;
   logic [1:0] w_alt_code;
   logic [1:0] w_same_code;
   mark_e      w_mark;

   assign w_mark      = mark_e'(i_mark);
   // Alternating pulse for ONE/B, repeated pulse for V.
   assign w_alt_code  = r_last_pos ? CODE_NEG : CODE_POS;
   assign w_same_code = r_last_pos ? CODE_POS : CODE_NEG;

   // Next symbol and polarity; code holds when nothing valid is shifted out.
   always_comb begin
      w_valid_nxt    = 1'b0;
      w_code_nxt     = r_code;
      w_last_pos_nxt = r_last_pos;
      if (i_shift && i_slot_valid) begin
         w_valid_nxt = 1'b1;
         case (w_mark)
            MARK_ONE, MARK_B: begin
               w_code_nxt     = w_alt_code;
               w_last_pos_nxt = ~r_last_pos;
            end
            MARK_V: begin
               w_code_nxt = w_same_code;
            end
            default: begin
               w_code_nxt = CODE_ZERO;
            end
         endcase
      end
   end

   // Output and last-polarity registers; last polarity resets negative so the first pulse is +1.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid    <= 1'b0;
         r_code     <= CODE_ZERO;
         r_last_pos <= 1'b0;
      end else begin
         r_valid    <= w_valid_nxt;
         r_code     <= w_code_nxt;
         r_last_pos <= w_last_pos_nxt;
      end
   end

   assign o_valid     = r_valid;
   assign o_hdb3_code = r_code;

endmodule

// File: rtl/hdbn_encoder.sv
// Parametrised HDB-n line encoder: stallable delay line with zero-run
// substitution (stage 1) feeding the polarity/output stage (stage 2).
module hdbn_encoder
   import hdbn_pkg::*;
#(
   parameter int unsigned ZMAX = 3
)
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_valid,
   input  logic       i_data,
   input  logic       i_ami_mode,
   output logic       o_valid,
   output logic [1:0] o_hdb3_code
);

   localparam int unsigned DEPTH = ZMAX + 1;
   localparam int unsigned CNT_W = $clog2(ZMAX + 2);

   slot_t [DEPTH-1:0] r_line;
   slot_t [DEPTH-1:0] w_line_nxt;
   logic  [CNT_W-1:0] r_zcnt;
   logic  [CNT_W-1:0] w_zcnt_nxt;
   logic              r_parity;
   logic              w_parity_nxt;
   slot_t             w_out_slot;

   // Shift in the accepted bit and substitute a V (and B on even parity)
   // once the zero run would exceed ZMAX. The B lands on the oldest run slot,
   // which is still resident, so stage 2 later sees the rewritten mark.
   always_comb begin
      w_line_nxt   = r_line;
      w_zcnt_nxt   = r_zcnt;
      w_parity_nxt = r_parity;
      if (i_valid) begin
         for (int i = 1; i < int'(DEPTH); i++) begin
            w_line_nxt[i] = r_line[i-1];
         end
         w_line_nxt[0].valid = 1'b1;
         w_line_nxt[0].mark  = i_data ? MARK_ONE : MARK_ZERO;
         if (i_data) begin
            w_zcnt_nxt   = '0;
            w_parity_nxt = ~r_parity;
         end else if (i_ami_mode) begin
            w_zcnt_nxt = '0;
         end else if (r_zcnt == CNT_W'(ZMAX)) begin
            w_line_nxt[0].mark = MARK_V;
            if (!r_parity) begin
               w_line_nxt[DEPTH-1].mark = MARK_B;
            end
            w_zcnt_nxt   = '0;
            w_parity_nxt = 1'b0;
         end else begin
            w_zcnt_nxt = r_zcnt + CNT_W'(1);
         end
      end
   end

   // Delay line, zero-run counter and pulse parity; reset drops all buffered bits.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_line   <= '0;
         r_zcnt   <= '0;
         r_parity <= 1'b0;
      end else begin
         r_line   <= w_line_nxt;
         r_zcnt   <= w_zcnt_nxt;
         r_parity <= w_parity_nxt;
      end
   end

   assign w_out_slot = r_line[DEPTH-1];

   hdbn_polarity u_polarity (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_shift      (i_valid),
      .i_slot_valid (w_out_slot.valid),
      .i_mark       (w_out_slot.mark),
      .o_valid      (o_valid),
      .o_hdb3_code  (o_hdb3_code)
   );

endmodule

// File: tb/tb_hdbn_encoder.sv
// Bench for hdbn_encoder: ZMAX=3 and ZMAX=5 instances share one stimulus
// stream; outputs are compared to an array-based HDB-n reference model.
module tb_hdbn_encoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       valid;
   logic       data;
   logic       mode;
   logic       v3, v5;
   logic [1:0] c3, c5;

   int n_err = 0;
   int n_chk = 0;

   int  in_bits[$];
   int  in_mode[$];
   int  got3[$];
   int  got5[$];
   int  expq[$];
   int  edge_cnt;
   int  first_v3;
   bit  gap_check;

   always #5 clk = ~clk;

   hdbn_encoder #(.ZMAX(3)) u_dut3 (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_valid     (valid),
      .i_data      (data),
      .i_ami_mode  (mode),
      .o_valid     (v3),
      .o_hdb3_code (c3)
   );

   hdbn_encoder #(.ZMAX(5)) u_dut5 (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_valid     (valid),
      .i_data      (data),
      .i_ami_mode  (mode),
      .o_valid     (v5),
      .o_hdb3_code (c5)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_run();
      in_bits.delete(); in_mode.delete();
      got3.delete(); got5.delete();
      edge_cnt = 0;
      first_v3 = -1;
   endtask

   task automatic do_reset(input bit check);
      rst_n = 1'b0; valid = 1'b0; data = 1'b0; mode = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      if (check) begin
         chk("reset_valid3", 32'(v3), 32'd0);
         chk("reset_code3",  32'(c3), 32'd0);
         chk("reset_valid5", 32'(v5), 32'd0);
         chk("reset_code5",  32'(c5), 32'd0);
      end
      rst_n = 1'b1;
      clear_run();
   endtask

   // One clock: drive inputs, sample both DUTs 1 time unit after the edge.
   task automatic push(input bit v, input bit d, input bit m);
      logic [1:0] prev3;
      prev3 = c3;
      valid = v; data = d; mode = m;
      @(posedge clk);
      #1;
      if (v) begin
         in_bits.push_back(int'(d));
         in_mode.push_back(int'(m));
         edge_cnt++;
      end
      if (v3) begin
         got3.push_back(int'(c3));
         if (first_v3 < 0) first_v3 = edge_cnt;
      end
      if (v5) got5.push_back(int'(c5));
      if (gap_check && !v) begin
         chk("gap_valid", 32'(v3), 32'd0);
         chk("gap_hold",  32'(c3), 32'(prev3));
      end
      valid = 1'b0;
   endtask

   task automatic push_zeros(input int n, input bit m);
      for (int i = 0; i < n; i++) push(1'b1, 1'b0, m);
   endtask

   // Reference: mark the whole stream (1=ONE, 2=B, 3=V), then assign polarity.
   // Symbol k is out once bit k+zmax+1 has been accepted.
   task automatic build_exp(input int zmax);
      int marks[$];
      int run, pulses, last, n;
      n = in_bits.size();
      run = 0; pulses = 0;
      expq.delete();
      for (int k = 0; k < n; k++) begin
         if (in_bits[k] != 0) begin
            marks.push_back(1); run = 0; pulses++;
         end else begin
            marks.push_back(0);
            if (in_mode[k] != 0) run = 0;
            else begin
               run++;
               if (run == zmax + 1) begin
                  marks[k] = 3;
                  if (pulses % 2 == 0) marks[k-zmax] = 2;
                  pulses = 0; run = 0;
               end
            end
         end
      end
      last = -1;
      for (int k = 0; k < n - zmax - 1; k++) begin
         if (marks[k] == 0) expq.push_back(0);
         else begin
            if (marks[k] != 3) last = -last;
            expq.push_back(last > 0 ? 1 : 2);
         end
      end
   endtask

   task automatic cmp_model(input string tag, input int zmax);
      int g[$];
      if (zmax == 3) g = got3; else g = got5;
      build_exp(zmax);
      chk({tag, "_len"}, 32'(g.size()), 32'(expq.size()));
      for (int i = 0; i < expq.size() && i < g.size(); i++)
         chk({tag, "_sym"}, 32'(g[i]), 32'(expq[i]));
   endtask

   task automatic cmp_const(input string tag, input int zmax, input int e[$]);
      int g[$];
      if (zmax == 3) g = got3; else g = got5;
      chk({tag, "_cnt"}, 32'(g.size() >= e.size()), 32'd1);
      for (int i = 0; i < e.size() && i < g.size(); i++)
         chk({tag, "_sym"}, 32'(g[i]), 32'(e[i]));
   endtask

   // Line-level properties of the ZMAX=3 output plus decode back to data.
   task automatic check_line3();
      int run, maxrun, n11, prev, bad;
      int dec[$];
      run = 0; maxrun = 0; n11 = 0; prev = 2; bad = 0;
      for (int k = 0; k < got3.size(); k++) begin
         if (got3[k] == 3) n11++;
         if (got3[k] == 0) begin
            run++;
            if (run > maxrun) maxrun = run;
            dec.push_back(0);
         end else begin
            run = 0;
            if (got3[k] == prev) begin
               dec.push_back(0);
               if (k >= 3) dec[k-3] = 0;
            end else begin
               dec.push_back(1);
               prev = got3[k];
            end
         end
      end
      for (int k = 0; k < dec.size(); k++)
         if (dec[k] != in_bits[k]) bad++;
      chk("rand_no11",    32'(n11), 32'd0);
      chk("rand_maxrun",  32'(maxrun <= 3), 32'd1);
      chk("rand_decode",  32'(bad), 32'd0);
      chk("rand_deccnt",  32'(dec.size() > 5000), 32'd1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "timeout");
   end

   initial begin
      int e[$];
      int pat[$];
      gap_check = 1'b0;

      // Reset state.
      do_reset(1'b1);

      // 1,0,0,0,0,1: odd parity, so 000V.
      foreach (pat[i]) pat.delete();
      pat = '{1, 0, 0, 0, 0, 1};
      foreach (pat[i]) push(1'b1, pat[i][0], 1'b0);
      push_zeros(4, 1'b0);
      chk("latency_first_valid", 32'(first_v3), 32'd5);
      e = '{1, 0, 0, 0, 1, 2};
      cmp_const("basic", 3, e);
      cmp_model("basic_model", 3);

      // Eight zeros from reset: B00V B00V.
      do_reset(1'b0);
      push_zeros(12, 1'b0);
      e = '{1, 0, 0, 1, 2, 0, 0, 2};
      cmp_const("zeros8", 3, e);

      // AMI mode: no substitution.
      do_reset(1'b0);
      push_zeros(8, 1'b1);
      push(1'b1, 1'b1, 1'b1);
      push(1'b1, 1'b1, 1'b1);
      push_zeros(4, 1'b1);
      e = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 2};
      cmp_const("ami", 3, e);

      // Stalls: valid pattern 1,0,0,1 repeated; same symbols as continuous.
      do_reset(1'b0);
      gap_check = 1'b1;
      pat = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
      foreach (pat[i]) begin
         push(1'b1, pat[i][0], 1'b0);
         if (i % 2 == 0) begin
            push(1'b0, 1'b1, 1'b0);
            push(1'b0, 1'b1, 1'b0);
         end
      end
      gap_check = 1'b0;
      e = '{1, 0, 0, 0, 1, 2};
      cmp_const("stall", 3, e);

      // Mid-run async reset, then a fresh run of four zeros.
      do_reset(1'b0);
      pat = '{1, 1, 1, 1, 1, 0, 0};
      foreach (pat[i]) push(1'b1, pat[i][0], 1'b0);
      chk("pre_reset_valid", 32'(v3), 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_reset_valid", 32'(v3), 32'd0);
      chk("async_reset_code",  32'(c3), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_run();
      push_zeros(8, 1'b0);
      e = '{1, 0, 0, 1};
      cmp_const("restart", 3, e);

      // ZMAX=5: six zeros give B0000V.
      do_reset(1'b0);
      push_zeros(12, 1'b0);
      e = '{1, 0, 0, 0, 0, 1};
      cmp_const("zmax5", 5, e);

      // Random stream with stalls, zero-heavy, mode 0.
      do_reset(1'b0);
      for (int i = 0; i < 10000; i++)
         push(($urandom % 4) != 0, ($urandom % 3) == 0, 1'b0);
      cmp_model("rand3", 3);
      cmp_model("rand5", 5);
      check_line3();

      // Random stream with occasional mode switches.
      do_reset(1'b0);
      mode = 1'b0;
      begin
         bit m;
         m = 1'b0;
         for (int i = 0; i < 2000; i++) begin
            if (($urandom % 16) == 0) m = ~m;
            push(1'b1, ($urandom % 3) == 0, m);
         end
      end
      cmp_model("mixed3", 3);
      cmp_model("mixed5", 5);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
